// File: rtl/imem_pkg.sv
// Shared types and default sizes for the instruction-memory arbiter slice.
package imem_pkg;

  typedef enum logic {
    FETCH  = 1'b0,
    LOADER = 1'b1
  } owner_t;

  typedef struct packed {
    logic   valid;
    owner_t owner;
  } tag_t;

  localparam int DEF_ADDR_W    = 32;
  localparam int DEF_DATA_W    = 32;
  localparam int DEF_LATENCY   = 2;
  localparam int DEF_MAX_BURST = 4;

  // Drop a fetch-owned entry when the fetch stage abandons its wrong-path reads.
  function automatic tag_t scrub_tag(input tag_t t, input logic inval_fetch);
    tag_t r;
    r = t;
    if (inval_fetch && (t.owner == FETCH)) begin
      r.valid = 1'b0;
    end else begin
      r.valid = t.valid;
    end
    return r;
  endfunction

endpackage

// File: rtl/imem_tag_pipe.sv
// Ownership tag shift register, one stage per cycle of BRAM read latency,
// with fetch-owned entries invalidated on flush.
module imem_tag_pipe
  import imem_pkg::*;
#(
  parameter int LATENCY = DEF_LATENCY
) (
  input  logic clk,
  input  logic reset,
  input  tag_t i_push,
  input  logic i_inval_fetch,
  output tag_t o_last
);

  tag_t r_stage [LATENCY];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LATENCY; i++) begin
        r_stage[i] <= '{valid: 1'b0, owner: FETCH};
      end
    end else begin
      r_stage[0] <= scrub_tag(i_push, i_inval_fetch);
      for (int i = 1; i < LATENCY; i++) begin
        r_stage[i] <= scrub_tag(r_stage[i-1], i_inval_fetch);
      end
    end
  end

  assign o_last = r_stage[LATENCY-1];

endmodule

// File: rtl/imem_arbiter.sv
// Single-port instruction BRAM arbiter between fetch and loader/debug, with
// loader priority, a bounded loader burst, and tagged routing of read data.
module imem_arbiter
  import imem_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int LATENCY   = DEF_LATENCY,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              flush,
  input  logic              l_req,
  input  logic              l_we,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  output logic              l_gnt,
  output logic              l_rvalid,
  output logic [DATA_W-1:0] l_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] BURST_SAT = CNT_W'(MAX_BURST);

  logic [CNT_W-1:0] r_burst_cnt;
  logic             w_f_win;
  tag_t             w_push;
  tag_t             w_last;

  // A flushing fetch stage is not a candidate, so the loader may use that slot.
  assign w_f_win = f_req && !flush && !reset &&
                   (!l_req || (r_burst_cnt == BURST_SAT));
  assign f_gnt   = w_f_win;
  assign l_gnt   = l_req && !reset && !w_f_win;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_burst_cnt <= '0;
    end else if (f_gnt || !f_req) begin
      r_burst_cnt <= '0;
    end else if (l_gnt && (r_burst_cnt != BURST_SAT)) begin
      r_burst_cnt <= r_burst_cnt + 1'b1;
    end else begin
      r_burst_cnt <= r_burst_cnt;
    end
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    w_push    = '{valid: 1'b0, owner: FETCH};
    if (f_gnt) begin
      mem_en    = 1'b1;
      mem_addr  = f_addr;
      w_push    = '{valid: 1'b1, owner: FETCH};
    end else if (l_gnt) begin
      mem_en    = 1'b1;
      mem_we    = l_we;
      mem_addr  = l_addr;
      mem_wdata = l_wdata;
      w_push    = '{valid: !l_we, owner: LOADER};
    end else begin
      w_push    = '{valid: 1'b0, owner: FETCH};
    end
  end

  imem_tag_pipe #(
    .LATENCY(LATENCY)
  ) u_tag_pipe (
    .clk          (clk),
    .reset        (reset),
    .i_push       (w_push),
    .i_inval_fetch(flush),
    .o_last       (w_last)
  );

  // A flush also kills the fetch response arriving in the flush cycle itself.
  assign f_rvalid = !reset && !flush && w_last.valid && (w_last.owner == FETCH);
  assign l_rvalid = !reset && w_last.valid && (w_last.owner == LOADER);
  assign f_rdata  = mem_rdata;
  assign l_rdata  = mem_rdata;

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter with a two-cycle BRAM model whose word at
// address a initially holds a+0x100.
module tb_imem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        f_req, flush, l_req, l_we;
  logic [31:0] f_addr, l_addr, l_wdata;
  logic        f_gnt, f_rvalid, l_gnt, l_rvalid, mem_en, mem_we;
  logic [31:0] f_rdata, l_rdata, mem_addr, mem_wdata, mem_rdata;

  int tests = 0;
  int fails = 0;

  logic [31:0] mem [0:63];
  logic [31:0] rd_q1, rd_q2;

  always #5 clk = ~clk;

  imem_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(2), .MAX_BURST(4)) dut (
    .clk(clk), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
    .flush(flush),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // BRAM model: write-first is irrelevant here, reads return after two edges.
  always @(posedge clk) begin
    if (mem_en && mem_we) mem[mem_addr[7:2]] <= mem_wdata;
    rd_q1 <= mem[mem_addr[7:2]];
    rd_q2 <= rd_q1;
  end
  assign mem_rdata = rd_q2;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic fr, input logic [31:0] fa, input logic fl,
                       input logic lr, input logic lw, input logic [31:0] la,
                       input logic [31:0] ld);
    @(negedge clk);
    f_req = fr; f_addr = fa; flush = fl;
    l_req = lr; l_we = lw; l_addr = la; l_wdata = ld;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    for (int k = 0; k < 64; k++) mem[k] = 32'(k * 4 + 256);
    reset = 1'b1;
    drive(1'b1, 32'h40, 1'b0, 1'b1, 1'b1, 32'h44, 32'hdead);
    chk("rst_f_gnt", f_gnt, 1'b0);
    chk("rst_l_gnt", l_gnt, 1'b0);
    chk("rst_mem_en", mem_en, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_rvalid", {f_rvalid, l_rvalid}, 2'b00);
    idle();
    reset = 1'b0;
    idle();

    // Fetch-only burst of three reads
    drive(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("f1_gnt", f_gnt, 1'b1);
    chk("f1_mem", {mem_en, mem_we, mem_addr}, {1'b1, 1'b0, 32'h0});
    drive(1'b1, 32'h4, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("f2_gnt", f_gnt, 1'b1);
    drive(1'b1, 32'h8, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("f3_gnt", f_gnt, 1'b1);
    chk("f1_resp", {f_rvalid, l_rvalid, f_rdata}, {2'b10, 32'h100});
    idle();
    chk("f2_resp", {f_rvalid, l_rvalid, f_rdata}, {2'b10, 32'h104});
    idle();
    chk("f3_resp", {f_rvalid, l_rvalid, f_rdata}, {2'b10, 32'h108});
    idle();
    chk("f_drain", {f_rvalid, l_rvalid}, 2'b00);

    // Loader write then fetch read of the same word
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h10, 32'h55);
    chk("lw_gnt", {l_gnt, f_gnt}, 2'b10);
    chk("lw_mem", {mem_en, mem_we, mem_addr, mem_wdata}, {2'b11, 32'h10, 32'h55});
    drive(1'b1, 32'h10, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("fr10_gnt", f_gnt, 1'b1);
    idle();
    chk("lw_no_rvalid", {f_rvalid, l_rvalid}, 2'b00);
    idle();
    chk("fr10_resp", {f_rvalid, l_rvalid, f_rdata}, {2'b10, 32'h55});
    idle();

    // Contention: four loader grants, then fetch
    for (int c = 0; c < 10; c++) begin
      drive(1'b1, 32'h0, 1'b0, 1'b1, 1'b0, 32'h20, 32'h0);
      chk($sformatf("cont%0d", c), {f_gnt, l_gnt}, (c % 5 == 4) ? 2'b10 : 2'b01);
    end
    idle(); idle(); idle();

    // Flush on the second of two back-to-back fetches
    drive(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("fl_t_gnt", f_gnt, 1'b1);
    drive(1'b1, 32'h4, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("fl_t1_gnt", {f_gnt, mem_en}, 2'b00);
    idle();
    chk("fl_t2_rv", f_rvalid, 1'b0);
    idle();
    chk("fl_t3_rv", f_rvalid, 1'b0);

    // Flush hits fetch only; interleaved loader read survives
    drive(1'b1, 32'h8, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("mix_f_gnt", f_gnt, 1'b1);
    drive(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h24, 32'h0);
    chk("mix_l_gnt", l_gnt, 1'b1);
    idle();
    chk("mix_f_rv", {f_rvalid, l_rvalid}, 2'b00);
    idle();
    chk("mix_l_resp", {f_rvalid, l_rvalid, l_rdata}, {2'b01, 32'h124});

    // Flush in the very cycle the fetch response arrives
    drive(1'b1, 32'hc, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    idle();
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("fl_same_cycle", f_rvalid, 1'b0);
    idle();

    // Reset with two reads in flight
    drive(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h4, 32'h0);
    reset = 1'b1;
    idle();
    chk("rst_inflight0", {f_rvalid, l_rvalid}, 2'b00);
    reset = 1'b0;
    idle();
    chk("rst_inflight1", {f_rvalid, l_rvalid}, 2'b00);
    idle();
    chk("rst_inflight2", {f_rvalid, l_rvalid}, 2'b00);

    // After reset the burst counter starts from zero
    for (int c = 0; c < 5; c++) begin
      drive(1'b1, 32'h0, 1'b0, 1'b1, 1'b0, 32'h28, 32'h0);
      chk($sformatf("post_rst%0d", c), {f_gnt, l_gnt}, (c == 4) ? 2'b10 : 2'b01);
      if (c == 2) chk("post_rst_resp", {l_rvalid, l_rdata}, {1'b1, 32'h128});
    end
    idle(); idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/imem_arbiter.md
# imem_arbiter

Shares the single-port instruction BRAM between the fetch stage and the program loader/debug port. Each cycle it grants at most one requester and drives the BRAM port. It tracks the owner of every in-flight read through a tag pipeline matched to the BRAM latency, and routes returned data to the correct requester. Flush support lets the fetch stage discard reads issued on a wrong path. Sits between the fetcher/loader and the instruction BRAM.

## Interface
- ADDR_W, 32, address width in bits
- DATA_W, 32, data width in bits
- LATENCY, 2, BRAM read latency in cycles (≥1)
- MAX_BURST, 4, consecutive loader grants allowed while fetch is waiting (≥1)

- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- f_req  in  1  fetch read request
- f_addr  in  ADDR_W  fetch read address
- f_gnt  out  1  fetch request accepted this cycle
- f_rvalid  out  1  fetch read data valid
- f_rdata  out  DATA_W  fetch read data
- flush  in  1  discard all fetch reads still in flight
- l_req  in  1  loader request
- l_we  in  1  loader write (1) / read (0)
- l_addr  in  ADDR_W  loader address
- l_wdata  in  DATA_W  loader write data
- l_gnt  out  1  loader request accepted this cycle
- l_rvalid  out  1  loader read data valid
- l_rdata  out  DATA_W  loader read data
- mem_en  out  1  BRAM enable
- mem_we  out  1  BRAM write enable
- mem_addr  out  ADDR_W  BRAM address
- mem_wdata  out  DATA_W  BRAM write data
- mem_rdata  in  DATA_W  BRAM read data, valid LATENCY cycles after the read is issued

## Operation
- Grants are combinational from the requests and the registered state. A request is accepted in the same cycle its grant is high. f_gnt and l_gnt are never both high.
- Arbitration:
  - Loader has priority.
  - Exception: fetch wins when f_req=1 and burst_cnt==MAX_BURST.
  - With a single requester, that requester wins.
- burst_cnt (width clog2(MAX_BURST+1)):
  - increments on each l_gnt while f_req=1;
  - clears on f_gnt, or on any cycle with f_req=0;
  - saturates at MAX_BURST.
- On a grant, drive the BRAM port from the winner:
  - mem_en=1;
  - mem_we = l_we for the loader, 0 for fetch;
  - mem_addr and mem_wdata from the winner.
- When no grant is issued, drive mem_en=0, mem_we=0 and zero on the other mem_* lines.
- Tag pipeline: LATENCY stages of {valid, owner}.
  - Stage 0 is loaded with valid=1 on a granted read. Loader writes and idle cycles load valid=0.
  - f_rvalid = last-stage valid and owner==FETCH.
  - l_rvalid = last-stage valid and owner==LOADER.
  - f_rdata and l_rdata are both wired to mem_rdata. They are meaningful only while the matching rvalid is high.
- flush=1 clears valid on every stage whose owner is FETCH, in that cycle's update. Loader entries are untouched.
  - f_gnt is forced to 0 during a flush cycle.
  - burst_cnt is unaffected by flush.
- Outputs while reset=1:
  - f_gnt, l_gnt, mem_en, mem_we are 0;
  - mem_addr and mem_wdata are 0;
  - f_rvalid and l_rvalid are 0.

## Timing
- Request-to-data latency is exactly LATENCY cycles after the grant cycle; there is no buffering. Requesters must sample rvalid every cycle, because responses cannot be stalled.
- Throughput is one access per cycle, back to back.
- Reset clears all tag stages to valid=0 and burst_cnt to 0. Reads in flight when reset asserts never produce an rvalid.
- Flush in the same cycle as a response: that fetch response is suppressed. A loader response in the same cycle still appears.
- Fetch starvation bound: with f_req held at 1 under continuous loader requests, fetch is granted within MAX_BURST+1 cycles.

## Structure
- Package imem_pkg holds:
  - typedef owner_t (enum FETCH=0, LOADER=1);
  - typedef tag_t struct {valid, owner};
  - default-width constants.
- Sub-module imem_tag_pipe holds the LATENCY-deep tag shift register, with a per-owner invalidate input for flush.

## Test plan
- Fetch-only, f_req=1 for addrs 0x0, 0x4, 0x8 on consecutive cycles, BRAM model returning addr+0x100 → f_gnt=1 on all three cycles; f_rvalid=1 with f_rdata 0x100, 0x104, 0x108 on cycles 2, 3, 4 after the first grant; l_rvalid stays 0.
- Loader write 0x55 to 0x10, then fetch read of 0x10 → l_gnt on the write cycle with no l_rvalid; f_rdata=0x55 appears LATENCY cycles after f_gnt.
- Contention, f_req=1 and l_req=1 continuously, MAX_BURST=4 → grant pattern L,L,L,L,F repeating; burst_cnt returns to 0 after each F.
- Fetch grants at t and t+1, flush=1 at t+1 → f_gnt=0 at t+1; f_rvalid stays 0 at t+2 and t+3.
- Interleaved fetch read at t and loader read at t+1, flush=1 at t+1 → loader response still delivered at t+3 (l_rvalid=1); the fetch response at t+2 is suppressed.
- Reset asserted with two reads in flight → no rvalid on either port afterwards; first grant after reset is released behaves normally, with burst_cnt=0.
